// File: rtl/fsm_pkg.sv
// Shared state encodings and widths for the input conditioning and FSM layer.
package fsm_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b11,
    CHK_LO    = 2'b10
  } deb_state_e;

  localparam int unsigned GLITCH_CNT_W = 8;

endpackage

// File: rtl/input_debounce_sync_ff.sv
// Plain SYNC_STAGES-deep flop chain bringing an asynchronous line into the clk domain.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronizes and debounces one raw input into a clean level plus edge strobes.
// Optional glitch counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module input_debounce
  import fsm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RST_LEVEL     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_raw,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic                    dout,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic                    busy
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam deb_state_e StRst = RST_LEVEL ? STABLE_HI : STABLE_LO;

  logic s;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_LEVEL  (RST_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din_raw),
    .q  (s)
  );

  deb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dout_q, dout_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            busy_q, busy_d;
  logic            abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StRst;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRst;
      cnt_q   <= '0;
      dout_q  <= RST_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

  // Clear takes priority over a coincident abort; count saturates at all-ones.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (abort && (glitch_cnt_q != '1)) begin
      glitch_cnt_d = glitch_cnt_q + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule
